lock_attempt_controller: RTL and testbench
==========================================

Name: lock_attempt_controller

Overview:
- Sequencer for the 6-digit combination lock. Accepts digit strobes from the debounced key/switch path and compares them against a programmable stored code.
- Counts failed attempts, enforces a lockout period after too many failures, and supports re-programming the code while open.
- Drives a 4-bit status code consumed by the HEX display decoder.

Parameters:
- CODE_LEN, 6, digits per attempt (2..8).
- MAX_FAILS, 3, consecutive failed attempts before lockout (1..15).
- LOCKOUT_CYCLES, 1000, clk cycles spent in lockout.
- DEFAULT_CODE, 24'h483815, reset code, one BCD nibble per digit, first digit in MS nibble (width 4*CODE_LEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- digit_valid  in  1  one-cycle digit strobe.
- digit  in  4  digit value; sampled only when digit_valid && digit_ready.
- digit_ready  out  1  high in ENTRY and PROGRAM.
- relock  in  1  pulse; closes the lock from OPEN.
- prog_req  in  1  pulse; enters PROGRAM from OPEN.
- status  out  4  display code (package enum).
- unlocked  out  1  high in OPEN and PROGRAM.
- locked_out  out  1  high in LOCKOUT.
- fail_count  out  4  consecutive failures.
- digit_idx  out  3  digits accepted in the current attempt or program pass.

Behaviour:
- Reset (rst low, async):
  - State ENTRY; digit_idx=0; mismatch=0; fail_count=0; timer=0.
  - Code registers = DEFAULT_CODE.
  - status=ST_ENTRY; unlocked=0; locked_out=0; digit_ready=1.
- All outputs are registered or decoded from registered state. None are combinational from inputs.
- A handshake is accepted when digit_valid && digit_ready. Strobes with digit_ready low are dropped, not queued.
- ENTRY:
  - Each accepted digit increments digit_idx.
  - mismatch |= (digit != code[digit_idx]). A digit >9 always sets mismatch.
  - When the CODE_LEN-th digit is accepted, go to CHECK on the next edge.
- CHECK (1 cycle, digit_ready=0):
  - mismatch=0: go to OPEN and clear fail_count.
  - mismatch=1: fail_count++. If the new value == MAX_FAILS, go to LOCKOUT with timer=LOCKOUT_CYCLES-1. Otherwise go to ENTRY with status=ST_FAIL held until the next accepted digit.
  - In every case, clear digit_idx and mismatch.
- LOCKOUT:
  - digit_ready=0; timer decrements each cycle.
  - At timer==0, go to ENTRY and clear fail_count.
  - relock and prog_req are ignored.
- OPEN:
  - relock: go to ENTRY.
  - prog_req: go to PROGRAM with digit_idx=0.
  - relock and prog_req in the same cycle: relock wins.
- PROGRAM:
  - Accepted digits 0..9 are written to code[digit_idx] and digit_idx increments. Digits >9 are dropped and digit_idx is unchanged.
  - After CODE_LEN digits, go to OPEN. The new code is used from the next attempt.
  - relock mid-program: abort to ENTRY. Digits already written are kept (partial update is allowed and documented).
- fail_count saturates at MAX_FAILS.
- digit_idx never exceeds CODE_LEN-1 outside the transition edge.
- Latency from the last digit to unlocked=1 is exactly 2 edges: the accept edge, then the CHECK edge.

Optional Feature:
- Macro: AUTO_RELOCK_EN.
- Defined:
  - Adds parameter OPEN_TIMEOUT (default 5000).
  - In OPEN, an idle counter reloads on entry and on any relock, prog_req or digit_valid activity.
  - At expiry the block goes to ENTRY, identical to relock.
  - PROGRAM is not timed.
- Undefined: OPEN persists until relock.

Decomposition:
- Package lock_pkg holds:
  - the state enum (ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT);
  - the status codes ST_ENTRY=4'h1, ST_FAIL=4'h9, ST_OPEN=4'h0, ST_PROG=4'h2, ST_LOCKOUT=4'hF;
  - the BCD digit type.
- Status encoding keeps 0000=open and 1111=closed, matching the existing display decoder.
- One sub-module, lock_countdown: a loadable down-counter with a zero flag. It is used for LOCKOUT and, when AUTO_RELOCK_EN is defined, for the OPEN timeout.

Test Plan:
- Reset, then digits 4,8,3,8,1,5 → CHECK one cycle after the 6th accept, then unlocked=1, status=4'h0, fail_count=0.
- Digits 4,8,3,8,1,6 three times (MAX_FAILS=3, LOCKOUT_CYCLES=20):
  - after attempts 1 and 2: fail_count=1 then 2, status=4'h9;
  - after attempt 3: locked_out=1 and digit_ready=0 for exactly 20 cycles, then ENTRY with fail_count=0.
- Digit 4'hC at index 0 followed by the correct remaining digits → fail. Digit strobes while digit_ready=0 are dropped and digit_idx is unchanged.
- Unlock, prog_req, then 1,2,3,4,5,A,6 → A is dropped and the code becomes 123456. relock, then enter 123456 → unlocked; 483815 → fail.
- In OPEN, relock and prog_req in the same cycle → ENTRY. Assert rst low mid-entry (after 3 digits) → immediate ENTRY with digit_idx=0 and the code restored to DEFAULT_CODE.
- AUTO_RELOCK_EN with OPEN_TIMEOUT=10: unlock, stay idle → unlocked falls after 10 cycles. A digit_valid pulse at cycle 8 extends the open period to 18 cycles.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types for the combination-lock sequencer: FSM states,
// HEX display status codes and the BCD digit type.
package lock_pkg;

   typedef enum logic [2:0] {
      S_ENTRY,
      S_CHECK,
      S_OPEN,
      S_PROGRAM,
      S_LOCKOUT
   } state_t;

   // 0000 = open and 1111 = closed, so the existing display decoder is unchanged
   typedef enum logic [3:0] {
      ST_OPEN    = 4'h0,
      ST_ENTRY   = 4'h1,
      ST_PROG    = 4'h2,
      ST_FAIL    = 4'h9,
      ST_LOCKOUT = 4'hF
   } status_t;

   typedef logic [3:0] bcd_t;

   function automatic logic is_bcd(input bcd_t d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/lock_countdown.sv
// Loadable down-counter with a zero flag. Load has priority over decrement.
// The counter stops at zero.
module lock_countdown #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Reload or count down toward zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (en && cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/lock_attempt_controller.sv
// Combination-lock attempt sequencer: digit entry, failed-attempt counting,
// lockout and re-programming of the stored code.
// Optional macro AUTO_RELOCK_EN closes the lock after OPEN_TIMEOUT idle cycles in OPEN.
module lock_attempt_controller
   import lock_pkg::*;
#(
   parameter int                  CODE_LEN       = 6,
   parameter int                  MAX_FAILS      = 3,
   parameter int                  LOCKOUT_CYCLES = 1000,
   parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 24'h483815
`ifdef AUTO_RELOCK_EN
   ,parameter int                 OPEN_TIMEOUT   = 5000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   output logic       digit_ready,
   input  logic       relock,
   input  logic       prog_req,
   output logic [3:0] status,
   output logic       unlocked,
   output logic       locked_out,
   output logic [3:0] fail_count,
   output logic [2:0] digit_idx
);

`ifdef AUTO_RELOCK_EN
   localparam int TMAX = (LOCKOUT_CYCLES > OPEN_TIMEOUT) ? LOCKOUT_CYCLES : OPEN_TIMEOUT;
`else
   localparam int TMAX = LOCKOUT_CYCLES;
`endif
   localparam int TW = $clog2(TMAX + 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic       mis_q, mis_d;
   logic       fflag_q, fflag_d;    // show ST_FAIL until the next accepted digit
   logic [3:0] fails_q, fails_d;
   logic [3:0] fails_inc;
   bcd_t       code_q [CODE_LEN];
   logic       code_we;
   logic       accept, last;
   logic          tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0] tmr_val;
   status_t    st;

   assign digit_ready = (state_q == S_ENTRY) || (state_q == S_PROGRAM);
   assign accept      = digit_valid && digit_ready;
   assign last        = (idx_q == 3'(CODE_LEN-1));
   assign fails_inc   = (fails_q == 4'(MAX_FAILS)) ? fails_q : fails_q + 4'd1;

   lock_countdown #(.W(TW)) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   // Next-state and datapath updates for the attempt sequencer.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      mis_d    = mis_q;
      fflag_d  = fflag_q;
      fails_d  = fails_q;
      code_we  = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;
      case (state_q)
         S_ENTRY: begin
            if (accept) begin
               fflag_d = 1'b0;
               mis_d   = mis_q | !is_bcd(digit) | (digit != code_q[idx_q]);
               if (last) begin
                  idx_d   = '0;
                  state_d = S_CHECK;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_CHECK: begin
            idx_d = '0;
            mis_d = 1'b0;
            if (!mis_q) begin
               state_d = S_OPEN;
               fails_d = '0;
`ifdef AUTO_RELOCK_EN
               tmr_load = 1'b1;
               tmr_val  = TW'(OPEN_TIMEOUT-1);
`endif
            end else begin
               fails_d = fails_inc;
               if (fails_inc == 4'(MAX_FAILS)) begin
                  state_d  = S_LOCKOUT;
                  tmr_load = 1'b1;
                  tmr_val  = TW'(LOCKOUT_CYCLES-1);
               end else begin
                  state_d = S_ENTRY;
                  fflag_d = 1'b1;
               end
            end
         end
         S_LOCKOUT: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               state_d = S_ENTRY;
               fails_d = '0;
            end
         end
         S_OPEN: begin
            if (relock) begin
               state_d = S_ENTRY;
            end else if (prog_req) begin
               state_d = S_PROGRAM;
               idx_d   = '0;
            end
`ifdef AUTO_RELOCK_EN
            else if (digit_valid) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(OPEN_TIMEOUT-1);
            end else if (tmr_zero) begin
               state_d = S_ENTRY;
            end
            tmr_en = 1'b1;
`endif
         end
         S_PROGRAM: begin
            // Abort keeps whatever digits were already written.
            if (relock) begin
               state_d = S_ENTRY;
               idx_d   = '0;
            end else if (accept && is_bcd(digit)) begin
               code_we = 1'b1;
               if (last) begin
                  idx_d   = '0;
                  state_d = S_OPEN;
`ifdef AUTO_RELOCK_EN
                  tmr_load = 1'b1;
                  tmr_val  = TW'(OPEN_TIMEOUT-1);
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = S_ENTRY;
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_ENTRY;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         fflag_q <= 1'b0;
         fails_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mis_q   <= mis_d;
         fflag_q <= fflag_d;
         fails_q <= fails_d;
      end
   end

   // Stored code, first digit at index 0 (MS nibble of DEFAULT_CODE).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CODE_LEN; i++)
            code_q[i] <= DEFAULT_CODE[4*(CODE_LEN-1-i) +: 4];
      end else if (code_we) begin
         code_q[idx_q] <= digit;
      end
   end

   // Display status decoded from registered state.
   always_comb begin
      st = ST_ENTRY;
      case (state_q)
         S_ENTRY:   st = fflag_q ? ST_FAIL : ST_ENTRY;
         S_CHECK:   st = ST_ENTRY;
         S_OPEN:    st = ST_OPEN;
         S_PROGRAM: st = ST_PROG;
         S_LOCKOUT: st = ST_LOCKOUT;
         default:   st = ST_ENTRY;
      endcase
   end

   assign status     = st;
   assign unlocked   = (state_q == S_OPEN) || (state_q == S_PROGRAM);
   assign locked_out = (state_q == S_LOCKOUT);
   assign fail_count = fails_q;
   assign digit_idx  = idx_q;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Directed bench for lock_attempt_controller (MAX_FAILS=3, LOCKOUT_CYCLES=20).
// Inputs change and outputs are sampled on the falling edge.
module tb_lock_attempt_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       digit_valid = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       relock = 1'b0;
   logic       prog_req = 1'b0;
   logic       digit_ready, unlocked, locked_out;
   logic [3:0] status, fail_count;
   logic [2:0] digit_idx;

   int n_run  = 0;
   int n_fail = 0;
   int n;

   always #5 clk = ~clk;

   lock_attempt_controller #(
      .CODE_LEN       (6),
      .MAX_FAILS      (3),
      .LOCKOUT_CYCLES (20),
      .DEFAULT_CODE   (24'h483815)
`ifdef AUTO_RELOCK_EN
      ,.OPEN_TIMEOUT  (10)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_valid (digit_valid),
      .digit       (digit),
      .digit_ready (digit_ready),
      .relock      (relock),
      .prog_req    (prog_req),
      .status      (status),
      .unlocked    (unlocked),
      .locked_out  (locked_out),
      .fail_count  (fail_count),
      .digit_idx   (digit_idx)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      @(negedge clk);
      digit_valid = 1'b0;
   endtask

   task automatic enter(input logic [23:0] c);
      for (int i = 0; i < 6; i++) send(c[4*(5-i) +: 4]);
   endtask

   // Enter a code and step past the CHECK edge.
   task automatic attempt(input logic [23:0] c);
      enter(c);
      @(negedge clk);
   endtask

   task automatic pulse_relock();
      relock = 1'b1;
      @(negedge clk);
      relock = 1'b0;
   endtask

   task automatic pulse_prog();
      prog_req = 1'b1;
      @(negedge clk);
      prog_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_idx",    digit_idx, 0);
      chk("rst_status", status, 4'h1);
      chk("rst_unl",    unlocked, 0);
      chk("rst_lko",    locked_out, 0);
      chk("rst_rdy",    digit_ready, 1);
      chk("rst_fails",  fail_count, 0);
      rst = 1'b1;

      // Correct code, 2-edge latency to unlocked
      send(4); send(8); send(3);
      chk("idx3", digit_idx, 3);
      send(8); send(1); send(5);
      chk("check_rdy", digit_ready, 0);
      chk("check_unl", unlocked, 0);
      @(negedge clk);
      chk("open_unl",    unlocked, 1);
      chk("open_status", status, 4'h0);
      chk("open_fails",  fail_count, 0);

      // relock and prog_req together: relock wins
      relock = 1'b1; prog_req = 1'b1;
      @(negedge clk);
      relock = 1'b0; prog_req = 1'b0;
      chk("both_unl",    unlocked, 0);
      chk("both_status", status, 4'h1);
      chk("both_rdy",    digit_ready, 1);

      // Three failures into lockout
      attempt(24'h483816);
      chk("f1_cnt",    fail_count, 1);
      chk("f1_status", status, 4'h9);
      send(4);
      chk("fail_clr",  status, 4'h1);
      send(8); send(3); send(8); send(1); send(6);
      @(negedge clk);
      chk("f2_cnt",    fail_count, 2);
      chk("f2_status", status, 4'h9);
      attempt(24'h483816);
      chk("lk_lko",    locked_out, 1);
      chk("lk_rdy",    digit_ready, 0);
      chk("lk_fails",  fail_count, 3);
      chk("lk_status", status, 4'hF);
      n = 0;
      while (locked_out && n < 200) begin
         n++;
         digit_valid = (n == 5);
         digit       = 4'd4;
         relock      = (n == 7);
         prog_req    = (n == 9);
         @(negedge clk);
      end
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      chk("lk_cycles",   n, 20);
      chk("lk_exit_f",   fail_count, 0);
      chk("lk_exit_st",  status, 4'h1);
      chk("lk_exit_rdy", digit_ready, 1);
      chk("lk_drop_idx", digit_idx, 0);

      // Non-BCD digit at index 0 always fails
      attempt(24'hC83815);
      chk("bad_fails",  fail_count, 1);
      chk("bad_status", status, 4'h9);
      attempt(24'h483815);
      chk("ok_unl",   unlocked, 1);
      chk("ok_fails", fail_count, 0);

      // Re-program to 123456, A dropped
      pulse_prog();
      chk("prg_status", status, 4'h2);
      chk("prg_unl",    unlocked, 1);
      chk("prg_rdy",    digit_ready, 1);
      chk("prg_idx0",   digit_idx, 0);
      send(1); send(2); send(3); send(4); send(5);
      chk("prg_idx5", digit_idx, 5);
      send(4'hA);
      chk("prg_dropA", digit_idx, 5);
      send(6);
      chk("prg_done_st",  status, 4'h0);
      chk("prg_done_idx", digit_idx, 0);
`ifndef AUTO_RELOCK_EN
      repeat (30) @(negedge clk);
      chk("open_hold", unlocked, 1);
`endif
      pulse_relock();
      chk("relock_unl", unlocked, 0);
      attempt(24'h123456);
      chk("new_code", unlocked, 1);
      pulse_relock();
      attempt(24'h483815);
      chk("old_code_f",  fail_count, 1);
      chk("old_code_st", status, 4'h9);

      // Asynchronous reset mid-entry restores defaults
      send(1); send(2); send(3);
      chk("pre_rst_idx", digit_idx, 3);
      rst = 1'b0;
      #1;
      chk("arst_idx",   digit_idx, 0);
      chk("arst_fails", fail_count, 0);
      chk("arst_st",    status, 4'h1);
      @(negedge clk);
      rst = 1'b1;
      attempt(24'h483815);
      chk("def_code", unlocked, 1);

      // Aborted program keeps the digits already written
      pulse_prog();
      send(9); send(9);
      pulse_relock();
      chk("abort_unl", unlocked, 0);
      attempt(24'h993815);
      chk("partial_code", unlocked, 1);
      pulse_relock();

`ifdef AUTO_RELOCK_EN
      attempt(24'h993815);
      n = 0;
      while (unlocked && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("auto_idle", n, 10);
      attempt(24'h993815);
      n = 0;
      while (unlocked && n < 100) begin
         n++;
         digit_valid = (n == 8);
         digit       = 4'd0;
         @(negedge clk);
      end
      digit_valid = 1'b0;
      chk("auto_extend", n, 18);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
